// File: rtl/miriscv_instr_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// miriscv_instr_mem_responder : fixed-latency instruction memory with load port
// Rev 1.0
// ---------------------------------------------------------------------------
module miriscv_instr_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1,
  parameter int XLEN        = 32
) (
  input  logic                           clk_i,
  input  logic                           arstn_i,
  input  logic                           instr_req_i,
  input  logic [XLEN-1:0]                instr_addr_i,
  output logic                           instr_rvalid_o,
  output logic [XLEN-1:0]                instr_rdata_o,
  output logic                           instr_err_o,
  input  logic                           ld_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr_i,
  input  logic [XLEN-1:0]                ld_wdata_i,
  output logic [31:0]                    req_cnt_o
);

  localparam int c_IDX_W = $clog2(DEPTH_WORDS);

  logic [XLEN-1:0]    r_mem [DEPTH_WORDS];
  logic               r_vld [LATENCY];
  logic [XLEN-1:0]    r_dat [LATENCY];
  logic               r_err [LATENCY];
  logic [31:0]        r_req_cnt;

  logic [c_IDX_W-1:0] w_idx;
  logic               w_misaligned;
  logic               w_out_of_range;
  logic               w_fault;

  assign w_idx          = instr_addr_i[c_IDX_W+1:2];
  assign w_misaligned   = |instr_addr_i[1:0];
  assign w_out_of_range = |instr_addr_i[XLEN-1:c_IDX_W+2];
  assign w_fault        = w_misaligned | w_out_of_range;

  // Memory has no reset so a program loaded during reset survives it.
  always_ff @(posedge clk_i) begin
    if (ld_we_i) begin
      r_mem[ld_addr_i] <= ld_wdata_i;
    end
  end

  // Stage 0 captures the read; the non-blocking read yields old data on a
  // same-cycle write to the same word.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_vld[i] <= 1'b0;
        r_dat[i] <= '0;
        r_err[i] <= 1'b0;
      end
      r_req_cnt <= 32'd0;
    end else begin
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
        r_err[i] <= r_err[i-1];
      end
      r_vld[0] <= instr_req_i;
      r_err[0] <= instr_req_i & w_fault;
      r_dat[0] <= (instr_req_i && !w_fault) ? r_mem[w_idx] : '0;
      if (instr_req_i) begin
        r_req_cnt <= r_req_cnt + 32'd1;
      end
    end
  end

  assign instr_rvalid_o = r_vld[LATENCY-1];
  assign instr_rdata_o  = r_dat[LATENCY-1];
  assign instr_err_o    = r_err[LATENCY-1];
  assign req_cnt_o      = r_req_cnt;

endmodule
`default_nettype wire
